instr_encoder_loader: RTL and testbench

//  Inverse of the instruction decode path: accepts decoded fields (kind, cond, phase-1 ALU op, regs, operand2/offset).

---
 rtl/instr_encoder_loader.sv | 139 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes decoded instruction fields into 32-bit ARM words and writes them sequentially into IMEM.
// Build option: define ENC_ILLEGAL_TRAP_EN to halt on an illegal alu_op instead of writing a NOP.
module instr_encoder_loader #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  kind,
   input  logic [3:0]  cond,
   input  logic [3:0]  alu_op,
   input  logic        s_bit,
   input  logic        imm,
   input  logic        load,
   input  logic        byte_sz,
   input  logic        link,
   input  logic [3:0]  rn,
   input  logic [3:0]  rd,
   input  logic [11:0] operand2,
   input  logic [23:0] offset24,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic [6:0]  count,
   output logic        full,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_FULL} state_t;

   state_t      state, state_nxt;
   logic [3:0]  opc;
   logic        opc_bad;
   logic        illegal;
   logic        accept;
   logic        last;
   logic [31:0] enc_word;

   // Phase-1 ALU code to ARM data-processing opcode.
   always_comb begin
      opc     = 4'b0000;
      opc_bad = 1'b0;
      unique case (alu_op)
         4'b0000: opc = 4'b0100;
         4'b0001: opc = 4'b0101;
         4'b0010: opc = 4'b0010;
         4'b0011: opc = 4'b0110;
         4'b0100: opc = 4'b0011;
         4'b0101: opc = 4'b0111;
         4'b0110: opc = 4'b0000;
         4'b0111: opc = 4'b1100;
         4'b1000: opc = 4'b0001;
         4'b1001: opc = 4'b1101;
         4'b1010: opc = 4'b1101;
         4'b1011: opc = 4'b1111;
         4'b1100: opc = 4'b1110;
         default: opc_bad = 1'b1;
      endcase
   end

   always_comb begin
      enc_word = 32'h0000_0000;
      unique case (kind)
         2'b00: enc_word = {cond, 2'b00, imm, opc, s_bit, rn, rd, operand2};
         2'b01: enc_word = {cond, 2'b01, imm, 1'b1, 1'b1, byte_sz, 1'b0, load, rn, rd, operand2};
         2'b10: enc_word = {cond, 3'b101, link, offset24};
         default: enc_word = 32'h0000_0000;
      endcase
   end

   // alu_op only has meaning for data-processing bundles.
   assign illegal  = (kind == 2'b00) && opc_bad;
   assign in_ready = (state == S_ACCEPT);
   assign accept   = in_valid && in_ready;
   assign last     = (count == 7'(DEPTH - 1));
   assign full     = (state == S_FULL);
   // NOTE: mem_we decodes straight from the state register so the async reset drops it in the same cycle.
   assign mem_we   = (state == S_WRITE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every variable assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:   state_nxt = S_ACCEPT;
            S_ACCEPT: if (accept) begin
`ifdef ENC_ILLEGAL_TRAP_EN
               state_nxt = illegal ? S_FULL : S_WRITE;
`else
               state_nxt = S_WRITE;
`endif
            end
            S_WRITE:  if (mem_ready) state_nxt = last ? S_FULL : S_ACCEPT;
            S_FULL:   state_nxt = S_FULL;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'h0000_0000;
         count     <= 7'd0;
         err       <= 1'b0;
      end else if (clear) begin
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'h0000_0000;
         count     <= 7'd0;
         err       <= 1'b0;
      end else begin
         if (accept) begin
            if (illegal) err <= 1'b1;
`ifdef ENC_ILLEGAL_TRAP_EN
            if (!illegal) mem_wdata <= enc_word;
`else
            mem_wdata <= illegal ? 32'h0000_0000 : enc_word;
`endif
         end
         if (state == S_WRITE && mem_ready) begin
            mem_addr <= mem_addr + 32'd4;
            count    <= count + 7'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=4): directed boundary steps plus a randomized
// phase checked against a field-level encoding model and an address/count scoreboard.
module tb_instr_encoder_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  kind = '0;
   logic [3:0]  cond = '0;
   logic [3:0]  alu_op = '0;
   logic        s_bit = 1'b0, imm = 1'b0, load = 1'b0, byte_sz = 1'b0, link = 1'b0;
   logic [3:0]  rn = '0, rd = '0;
   logic [11:0] operand2 = '0;
   logic [23:0] offset24 = '0;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [6:0]  count;
   logic        full, err;

   int errors = 0;
   int checks = 0;

   // Scoreboard state.
   int          exp_count = 0;
   logic [31:0] exp_addr  = BASE;
   logic        exp_err   = 1'b0;
   bit          halted    = 1'b0;

   // ARM opcode for each legal phase-1 ALU code.
   int opc_tab [13] = '{4, 5, 2, 6, 3, 7, 0, 12, 1, 13, 13, 15, 14};

   instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .kind(kind), .cond(cond), .alu_op(alu_op), .s_bit(s_bit), .imm(imm), .load(load),
      .byte_sz(byte_sz), .link(link), .rn(rn), .rd(rd), .operand2(operand2), .offset24(offset24),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_illegal();
      return (kind == 2'd0) && (alu_op > 4'd12);
   endfunction

   function automatic logic [31:0] model_word();
      logic [31:0] w;
      w = 32'(cond) << 28;
      case (kind)
         2'd0: w = w | (32'(imm) << 25) | (32'(opc_tab[alu_op]) << 21) | (32'(s_bit) << 20)
                     | (32'(rn) << 16) | (32'(rd) << 12) | 32'(operand2);
         2'd1: w = w | (32'd1 << 26) | (32'(imm) << 25) | (32'd1 << 24) | (32'd1 << 23)
                     | (32'(byte_sz) << 22) | (32'(load) << 20) | (32'(rn) << 16)
                     | (32'(rd) << 12) | 32'(operand2);
         2'd2: w = w | (32'd5 << 25) | (32'(link) << 24) | 32'(offset24);
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   // Push the current field bundle, stall the memory for `stall` cycles, then complete the write.
   task automatic send(input int stall);
      bit          ok;
      bit          bad;
      logic [31:0] w;
      wait_ready(ok);
      if (!ok) return;
      bad = model_illegal();
      w   = bad ? 32'h0 : model_word();
      if (bad) exp_err = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
      if (bad) begin
         halted = 1'b1;
         check("trap_err",   32'(err),    32'd1);
         check("trap_full",  32'(full),   32'd1);
         check("trap_no_we", 32'(mem_we), 32'd0);
         check("trap_count", 32'(count),  32'(exp_count));
         return;
      end
`endif
      check("we_on",    32'(mem_we),   32'd1);
      check("addr",     mem_addr,      exp_addr);
      check("wdata",    mem_wdata,     w);
      check("ready_lo", 32'(in_ready), 32'd0);
      check("err",      32'(err),      32'(exp_err));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_we",    32'(mem_we), 32'd1);
         check("stall_wdata", mem_wdata,   w);
         check("stall_count", 32'(count),  32'(exp_count));
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      exp_count++;
      exp_addr = exp_addr + 32'd4;
      check("count",   32'(count),  32'(exp_count));
      check("we_off",  32'(mem_we), 32'd0);
      check("full",    32'(full),   32'(exp_count == DEPTH));
      check("addr_up", mem_addr,    exp_addr);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      exp_count = 0;
      exp_addr  = BASE;
      exp_err   = 1'b0;
      halted    = 1'b0;
      check("clr_count", 32'(count),  32'd0);
      check("clr_addr",  mem_addr,    BASE);
      check("clr_err",   32'(err),    32'd0);
      check("clr_full",  32'(full),   32'd0);
      check("clr_we",    32'(mem_we), 32'd0);
      @(negedge clk);
      check("clr_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic set_fields(input logic [1:0] k, input logic [3:0] c, input logic [3:0] op,
                             input logic i, input logic l, input logic b, input logic lk,
                             input logic [3:0] n, input logic [3:0] d, input logic [11:0] o2,
                             input logic [23:0] o24);
      kind = k; cond = c; alu_op = op; imm = i; load = l; byte_sz = b; link = lk;
      rn = n; rd = d; operand2 = o2; offset24 = o24; s_bit = 1'b0;
   endtask

   initial begin
      bit ok;
      // Reset state.
      #12;
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_addr",  mem_addr,       BASE);
      check("rst_wdata", mem_wdata,      32'd0);
      check("rst_count", 32'(count),     32'd0);
      check("rst_full",  32'(full),      32'd0);
      check("rst_err",   32'(err),       32'd0);
      check("rst_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD, LDR, BL with a 3-cycle memory stall, then a NOP fills DEPTH=4.
      set_fields(2'b00, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 12'h005, 24'h0);
      check("model_add", model_word(), 32'hE282_1005);
      send(0);
      set_fields(2'b01, 4'hE, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd3, 12'h008, 24'h0);
      check("model_ldr", model_word(), 32'hE594_3008);
      send(0);
      set_fields(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 12'h000, 24'h000010);
      check("model_bl", model_word(), 32'hEB00_0010);
      send(3);
      set_fields(2'b11, 4'h5, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 12'hABC, 24'h123456);
      send(1);

      // Fifth bundle while full is never accepted.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_ready", 32'(in_ready), 32'd0);
         check("full_we",    32'(mem_we),   32'd0);
         check("full_count", 32'(count),    32'd4);
         check("full_flag",  32'(full),     32'd1);
      end
      in_valid = 1'b0;
      do_clear();

      // clear wins over a handshake in the same cycle.
      wait_ready(ok);
      in_valid = 1'b1;
      clear    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      check("clrpri_we",    32'(mem_we), 32'd0);
      check("clrpri_count", 32'(count),  32'd0);

      // clear during WRITE drops the pending word even with mem_ready high.
      wait_ready(ok);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("clrwr_we_on", 32'(mem_we), 32'd1);
      clear     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      clear     = 1'b0;
      mem_ready = 1'b0;
      check("clrwr_we",    32'(mem_we), 32'd0);
      check("clrwr_count", 32'(count),  32'd0);
      check("clrwr_addr",  mem_addr,    BASE);

      // Illegal alu_op.
      set_fields(2'b00, 4'hE, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0);
      send(0);
      check("illegal_err", 32'(err), 32'd1);
      do_clear();

      // Randomized bundles against the model.
      for (int n = 0; n < 40; n++) begin
         if (exp_count == DEPTH || halted) do_clear();
         kind     = 2'($urandom_range(0, 3));
         cond     = 4'($urandom);
         alu_op   = 4'($urandom);
         s_bit    = 1'($urandom);
         imm      = 1'($urandom);
         load     = 1'($urandom);
         byte_sz  = 1'($urandom);
         link     = 1'($urandom);
         rn       = 4'($urandom);
         rd       = 4'($urandom);
         operand2 = 12'($urandom);
         offset24 = 24'($urandom);
         send(int'($urandom_range(0, 2)));
      end
      if (exp_count == DEPTH || halted) do_clear();

      // Async reset mid-WRITE.
      set_fields(2'b00, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 12'h005, 24'h0);
      wait_ready(ok);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("rstwr_we_on", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rstwr_we_async", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rstwr_count", 32'(count), 32'd0);
      check("rstwr_addr",  mem_addr,   BASE);
      check("rstwr_err",   32'(err),   32'd0);
      exp_count = 0;
      exp_addr  = BASE;
      exp_err   = 1'b0;
      send(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
